// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: in-order fetch with redirect flush and a small instruction buffer.
// Define CONFIG_FETCH_PREFETCH_EN for a 2-deep buffer (1 inst/cycle); otherwise it is 1-deep.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
`ifdef CONFIG_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   word_q [DEPTH];
    logic [31:0]   word_d [DEPTH];
    logic [31:0]   epc_q [DEPTH];
    logic [31:0]   epc_d [DEPTH];
    logic [CW-1:0] count_q, count_d, outst_q, outst_d, stale_q, stale_d;
    logic [OW-1:0] occ;
    logic [31:0]   resp_pc;
    logic          deq, acc, resp_in;

    assign inst_valid     = count_q != '0;
    assign inst           = word_q[0];
    assign inst_pc        = epc_q[0];
    assign imem_req_addr  = pc_q;
    assign deq            = inst_valid && inst_ready;
    // Occupancy counts buffered words plus words still in flight, net of this cycle's dequeue.
    assign occ            = OW'(count_q) + OW'(outst_q) - OW'(deq);
    assign imem_req_valid = state_q == FETCH && !redirect_valid && occ < OW'(DEPTH);
    assign acc            = imem_req_valid && imem_req_ready;
    assign resp_in        = imem_resp_valid && state_q != BOOT;
    // Responses are in order, so the oldest in-flight request sits outst_q words behind the fetch PC.
    assign resp_pc        = pc_q - (32'(outst_q) << 2);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        outst_d = outst_q;
        stale_d = stale_q;
        word_d  = word_q;
        epc_d   = epc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~32'd3;
            count_d = '0;
            outst_d = '0;
            stale_d = (state_q == FLUSH ? stale_q : outst_q) - CW'(resp_in);
            state_d = stale_d != '0 ? FLUSH : FETCH;
        end else if (state_q == BOOT) begin
            state_d = FETCH;
        end else if (state_q == FLUSH) begin
            stale_d = stale_q - CW'(resp_in);
            state_d = stale_d == '0 ? FETCH : FLUSH;
        end else begin
            pc_d    = pc_q + (acc ? 32'd4 : 32'd0);
            outst_d = outst_q + CW'(acc) - CW'(resp_in);
            count_d = count_q + CW'(resp_in) - CW'(deq);
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (deq) begin
                    word_d[i] = word_q[(i + 1) % DEPTH];
                    epc_d[i]  = epc_q[(i + 1) % DEPTH];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (resp_in && CW'(i) == count_q - CW'(deq)) begin
                    word_d[i] = imem_resp_data;
                    epc_d[i]  = resp_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
            outst_q <= '0;
            stale_q <= '0;
            word_q  <= '{default: '0};
            epc_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            outst_q <= outst_d;
            stale_q <= stale_d;
            word_q  <= word_d;
            epc_q   <= epc_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with an in-order memory model of programmable latency.
module tb_instruction_fetch_unit;
`ifdef CONFIG_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n, redirect_valid, imem_req_ready, imem_resp_valid, inst_ready;
    logic [31:0] redirect_pc, imem_resp_data;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_req_addr, inst, inst_pc;

    int          pass_n = 0, total_n = 0, n_acc = 0, cyc = 0, lat = 1;
    logic [31:0] exp_req[$], exp_pc[$], pa[$];
    int          pd[$];
    logic        have_h;
    logic [31:0] hp, hw;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        total_n++;
        if (a === e) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, a, e);
    endtask

    task automatic fail(input string nm, input logic [31:0] a);
        total_n++;
        $display("FAIL %s: got %h, nothing expected", nm, a);
    endtask

    task automatic push_seq(input logic [31:0] base, input int n, input bit deliver);
        for (int i = 0; i < n; i++) begin
            exp_req.push_back(base + 32'(4 * i));
            if (deliver) exp_pc.push_back(base + 32'(4 * i));
        end
    endtask

    // One clock: record acceptance, advance, then present any due memory response.
    task automatic step(input bit idle);
        #1;
        if (idle) check("req_withdrawn", {31'b0, imem_req_valid}, 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            pa.push_back(imem_req_addr);
            pd.push_back(cyc + lat);
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pa.size() > 0 && pd[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem(pa.pop_front());
            void'(pd.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    task automatic run_to(input int tgt);
        int k = 0;
        while (n_acc < tgt && k < 100) begin
            step(1'b0);
            k++;
        end
        check("accept_timeout", 32'(n_acc), 32'(tgt));
        imem_req_ready = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_pc.size() > 0 && k < 60) begin
            step(1'b0);
            k++;
        end
        check("drain_timeout", 32'(exp_pc.size()), 32'd0);
    endtask

    task automatic fill_outstanding();
        int k = 0;
        while (pa.size() < DEPTH && k < 20) begin
            step(1'b0);
            k++;
        end
        check("fill_timeout", 32'(pa.size()), 32'(DEPTH));
    endtask

    task automatic check_reset_outputs();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, RST_PC);
    endtask

    // Monitor: compares every accepted request and every consumed instruction against the scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                if (exp_req.size() == 0) fail("req_unexpected", imem_req_addr);
                else check("req_addr", imem_req_addr, exp_req.pop_front());
            end
            if (rst_n && inst_valid && inst_ready) begin
                if (exp_pc.size() == 0) fail("inst_unexpected", inst_pc);
                else begin
                    e = exp_pc.pop_front();
                    check("inst_pc", inst_pc, e);
                    check("inst_word", inst, mem(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        // Straight-line fetch from reset with 1-cycle memory.
        push_seq(32'h0040_0000, 8, 1'b1);
        run_to(8);
        drain();
        // Decode stall: bounded prefetch, stable head.
        push_seq(32'h0040_0020, 4, 1'b1);
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        have_h = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("outst_bound", {31'b0, pa.size() <= DEPTH}, 32'd1);
            if (inst_valid) begin
                if (!have_h) begin
                    have_h = 1'b1; hp = inst_pc; hw = inst;
                end else begin
                    check("head_pc_stable", inst_pc, hp);
                    check("head_word_stable", inst, hw);
                end
            end
        end
        check("stall_accepts", 32'(n_acc), 32'(8 + DEPTH));
        inst_ready = 1'b1;
        run_to(12);
        drain();
        // Redirect with DEPTH requests in flight: stale words dropped, target aligned.
        push_seq(32'h0040_0030, DEPTH, 1'b0);
        lat = 3;
        imem_req_ready = 1'b1;
        fill_outstanding();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step(1'b1);
        redirect_valid = 1'b0;
        lat = 1;
        push_seq(32'h0000_0100, 4, 1'b1);
        run_to(n_acc + 4);
        drain();
        // Redirect in the same cycle as a response.
        push_seq(32'h0000_0110, DEPTH, 1'b0);
        lat = 2;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 10 && !imem_resp_valid; k++) step(1'b0);
        check("resp_seen", {31'b0, imem_resp_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step(1'b1);
        redirect_valid = 1'b0;
        lat = 1;
        push_seq(32'h0000_0200, 3, 1'b1);
        imem_req_ready = 1'b1;
        run_to(n_acc + 3);
        drain();
        // Address wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step(1'b1);
        redirect_valid = 1'b0;
        push_seq(32'hFFFF_FFF8, 4, 1'b1);
        imem_req_ready = 1'b1;
        run_to(n_acc + 4);
        drain();
        // Reset pulse while flushing.
        push_seq(32'h0000_0008, DEPTH, 1'b0);
        lat = 3;
        imem_req_ready = 1'b1;
        fill_outstanding();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step(1'b1);
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        imem_resp_valid = 1'b0;
        pa.delete();
        pd.delete();
        #1;
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        push_seq(RST_PC, 4, 1'b1);
        run_to(n_acc + 4);
        drain();
        check("exp_req_left", 32'(exp_req.size()), 32'd0);
        check("exp_inst_left", 32'(exp_pc.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
